// File: rtl/if_stage.sv
// Instruction fetch stage: issues SRAM fetches at nextpc, holds the fetched
// PC/instruction for decode, and buffers the SRAM word while decode stalls.
//
// Handshake: fs_to_ds_valid / ds_allowin follow valid/ready semantics. An
// instruction moves to decode on a rising edge where both are 1. While valid
// is high and ready is low, fs_pc and fs_inst stay stable. The only way an
// offered instruction is withdrawn is a redirect (br_taken), which cancels it.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h1c000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ds_allowin,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        inst_sram_en,
   output logic        inst_sram_we,
   output logic [31:0] inst_sram_addr,
   output logic [31:0] inst_sram_wdata,
   input  logic [31:0] inst_sram_rdata,
   output logic        fs_to_ds_valid,
   output logic [31:0] fs_pc,
   output logic [31:0] fs_inst
);

   logic        fs_valid;
   logic        fs_allowin;
   logic [31:0] nextpc;
   logic        inst_buf_valid;
   logic [31:0] inst_buf;

   // A redirect always overrides sequential flow; the +4 wraps silently.
   assign nextpc = br_taken ? br_target : fs_pc + 32'd4;

   // Fetch may advance when empty, when decode takes the current word, or
   // when a redirect discards it.
   assign fs_allowin      = !fs_valid | ds_allowin | br_taken;
   assign inst_sram_en    = fs_allowin & !reset;
   assign inst_sram_addr  = nextpc;
   assign inst_sram_we    = 1'b0;
   assign inst_sram_wdata = 32'd0;

   // The wrong-path instruction is hidden from decode in the redirect cycle.
   assign fs_to_ds_valid = fs_valid & !br_taken;

   // SRAM data is only valid for one cycle, so a stalled word comes from the buffer.
   assign fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata;

   // PC register: reset to RESET_PC-4 so the first fetch lands on RESET_PC.
   always_ff @(posedge clk) begin
      if (reset) begin
         fs_valid <= 1'b0;
         fs_pc    <= RESET_PC - 32'd4;
      end else if (inst_sram_en) begin
         fs_valid <= 1'b1;
         fs_pc    <= nextpc;
      end
   end

   // Instruction buffer: capture the SRAM word on the first stalled edge,
   // drop it whenever a new fetch is issued.
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_buf_valid <= 1'b0;
      end else if (inst_sram_en) begin
         inst_buf_valid <= 1'b0;
      end else if (fs_valid && !ds_allowin && !br_taken && !inst_buf_valid) begin
         inst_buf_valid <= 1'b1;
         inst_buf       <= inst_sram_rdata;
      end
   end

endmodule
